// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory bus between the LSU and memory/interconnect.
// Address phase req/gnt, response phase rvalid/err/rdata.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  data_req;
  logic                  data_gnt;
  logic                  data_rvalid;
  logic                  data_err;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_we;
  logic [3:0]            data_be;
  logic [31:0]           data_wdata;
  logic [31:0]           data_rdata;

  modport master (
    output data_req,
    output data_addr,
    output data_we,
    output data_be,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_err,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_addr,
    input  data_we,
    input  data_be,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_err,
    output data_rdata
  );

endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one outstanding load/store on the data bus, byte lanes + extension.
// Define MISALIGNED_SPLIT_EN to split word-crossing misaligned accesses into two beats.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_en_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_done_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_err_o,
  load_store_unit_if.master     bus
);

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {
    IDLE, ADDR, RESP, ADDR_HI, RESP_HI, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, ADDR, RESP, DONE
  } state_t;
`endif

  localparam logic [31:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t                state;
  logic [31:0]           cnt;
  logic                  req_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  sext_q;

  logic [1:0]  off;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic        sz_bad;
  logic [3:0]  base_be;
  logic [31:0] rep;
  logic        mis;
  logic        ok;
  logic [3:0]  lo_be;
  logic [31:0] lo_wd;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        to_hit;

  assign bus.data_req   = req_q;
  assign bus.data_we    = we_q;
  assign bus.data_be    = be_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign lsu_done_o     = done_q;
  assign lsu_err_o      = err_q;
  assign lsu_rdata_o    = rdata_q;

  always_comb begin
    off    = lsu_addr_i[1:0];
    sz_b   = 1'b0;
    sz_h   = 1'b0;
    sz_w   = 1'b0;
    sz_bad = 1'b0;
    unique case (1'b1)
      (lsu_size_i == 2'b00): sz_b   = 1'b1;
      (lsu_size_i == 2'b01): sz_h   = 1'b1;
      (lsu_size_i == 2'b10): sz_w   = 1'b1;
      default:               sz_bad = 1'b1;
    endcase
    base_be = sz_w ? 4'b1111 :
              sz_h ? 4'b0011 :
              sz_b ? 4'b0001 : 4'b0000;
    rep = sz_b ? {4{lsu_wdata_i[7:0]}} :
          sz_h ? {2{lsu_wdata_i[15:0]}} :
                 lsu_wdata_i;
    mis = (sz_h & off[0]) |
          (sz_w & (off != 2'b00));
  end

`ifdef MISALIGNED_SPLIT_EN
  logic        cross;
  logic [7:0]  be64;
  logic [63:0] wd64;
  logic        split_q;
  logic [3:0]  hi_be_q;
  logic [31:0] hi_wd_q;
  logic [31:0] lo_q;
  logic [63:0] merged;

  assign cross = (sz_h & (off == 2'b11)) |
                 (sz_w & (off != 2'b00));
  assign be64  = {4'b0000, base_be} << off;
  assign wd64  = {32'b0, lsu_wdata_i} << {off, 3'b000};
  assign lo_be = be64[3:0];
  // Aligned stores keep plain lane replication.
  assign lo_wd = mis ? wd64[31:0] : rep;
  assign ok    = !sz_bad;

  assign merged = split_q ?
    {bus.data_rdata, lo_q} :
    {32'b0, bus.data_rdata};
  assign sh = 32'(merged >> {off_q, 3'b000});
`else
  assign lo_be = base_be << off;
  assign lo_wd = rep;
  assign ok    = !sz_bad && !mis;
  assign sh    = bus.data_rdata >> {off_q, 3'b000};
`endif

  always_comb begin
    ext = sh;
    unique case (1'b1)
      (size_q == 2'b00):
        ext = sext_q ? {{24{sh[7]}}, sh[7:0]}
                     : {24'b0, sh[7:0]};
      (size_q == 2'b01):
        ext = sext_q ? {{16{sh[15]}}, sh[15:0]}
                     : {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign to_hit = (TIMEOUT_CYCLES > 0) &&
                  (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
      hi_be_q <= '0;
      hi_wd_q <= '0;
      lo_q    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (lsu_en_i) begin
            off_q  <= off;
            size_q <= lsu_size_i;
            sext_q <= lsu_sign_ext_i;
            if (ok) begin
              state   <= ADDR;
              req_q   <= 1'b1;
              we_q    <= lsu_we_i;
              be_q    <= lo_be;
              wdata_q <= lo_wd;
              addr_q  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
              split_q <= cross;
              hi_be_q <= be64[7:4];
              hi_wd_q <= wd64[63:32];
`endif
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.data_gnt) begin
            state <= RESP;
            req_q <= 1'b0;
            cnt   <= '0;
          end else if (to_hit) begin
            state  <= DONE;
            req_q  <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: begin
          if (bus.data_rvalid) begin
            cnt <= '0;
`ifdef MISALIGNED_SPLIT_EN
            // First beat of a split: park the low word, issue A+4.
            if (split_q && !bus.data_err) begin
              state   <= ADDR_HI;
              req_q   <= 1'b1;
              addr_q  <= addr_q + ADDR_WIDTH'(4);
              be_q    <= hi_be_q;
              wdata_q <= hi_wd_q;
              lo_q    <= bus.data_rdata;
            end else
`endif
            begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= bus.data_err;
              if (bus.data_err)
                rdata_q <= '0;
              else if (!we_q)
                rdata_q <= ext;
            end
          end else if (to_hit) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        ADDR_HI: begin
          if (bus.data_gnt) begin
            state <= RESP_HI;
            req_q <= 1'b0;
            cnt   <= '0;
          end else if (to_hit) begin
            state  <= DONE;
            req_q  <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP_HI: begin
          if (bus.data_rvalid) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= bus.data_err;
            cnt    <= '0;
            if (bus.data_err)
              rdata_q <= '0;
            else if (!we_q)
              rdata_q <= ext;
          end else if (to_hit) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`endif
        DONE: begin
          // lsu_en_i deliberately ignored here.
          state  <= IDLE;
          done_q <= 1'b0;
          err_q  <= 1'b0;
          cnt    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a bus responder model.
// Build with MISALIGNED_SPLIT_EN to exercise split accesses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_en_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_en_i       (lsu_en_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_sign_ext_i (lsu_sign_ext_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_done_o     (lsu_done_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_err_o      (lsu_err_o),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gnt_wait;
    logic [31:0] rdata;
    logic        err;
    logic        drop;
  } beat_t;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  beat_t beat_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  logic  gnt_block = 1'b0;
  logic  stray = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input logic [31:0] addr,
                          input logic we,
                          input logic [3:0] be,
                          input logic [31:0] wdata,
                          input int gnt_wait,
                          input logic [31:0] rdata,
                          input logic err,
                          input logic drop);
    beat_t b;
    b.addr = addr; b.we = we; b.be = be;
    b.wdata = wdata; b.gnt_wait = gnt_wait;
    b.rdata = rdata; b.err = err; b.drop = drop;
    beat_q.push_back(b);
  endtask

  // Bus responder: grants queued beats, answers the cycle after grant.
  initial begin : responder
    beat_t cur;
    logic  pend;
    int    wcnt;
    pend = 1'b0;
    wcnt = 0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_err    = 1'b0;
    bus.data_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b0;
      bus.data_err    = 1'b0;
      if (stray) begin
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'h5555AAAA;
        stray = 1'b0;
      end else if (pend) begin
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = cur.rdata;
        bus.data_err    = cur.err;
        pend = 1'b0;
      end else if (rst_n && bus.data_req && !gnt_block) begin
        if (beat_q.size() == 0) begin
          check("req_expected", bus.data_req, 0);
        end else if (wcnt < beat_q[0].gnt_wait) begin
          wcnt++;
        end else begin
          cur = beat_q.pop_front();
          wcnt = 0;
          bus.data_gnt = 1'b1;
          check("bus_addr", bus.data_addr, cur.addr);
          check("bus_we", bus.data_we, cur.we);
          check("bus_be", bus.data_be, cur.be);
          if (cur.we)
            check("bus_wdata", bus.data_wdata, cur.wdata);
          pend = !cur.drop;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && lsu_done_o) begin
      if (exp_q.size() == 0) begin
        check("done_expected", lsu_done_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("err", lsu_err_o, e.err);
        if (e.chk_rd)
          check("rdata", lsu_rdata_o, e.rdata);
      end
    end
  end

  task automatic run_op(input logic we,
                        input logic [1:0] size,
                        input logic sext,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic exp_err,
                        input logic chk_rd,
                        input logic [31:0] exp_rd,
                        input int exp_lat);
    exp_t e;
    int   lat;
    logic seen;
    e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
    exp_q.push_back(e);
    lsu_en_i       = 1'b1;
    lsu_we_i       = we;
    lsu_size_i     = size;
    lsu_sign_ext_i = sext;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      seen = lsu_done_o;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", lat, exp_lat);
      check("req_at_done", bus.data_req, 0);
    end
    @(posedge clk); #1;
    lsu_en_i = 1'b0;
    check("no_restart", bus.data_req, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    lsu_en_i       = 1'b0;
    lsu_we_i       = 1'b0;
    lsu_size_i     = 2'b00;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i     = '0;
    lsu_wdata_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", lsu_done_o, 0);
    check("rst_err", lsu_err_o, 0);
    check("rst_rdata", lsu_rdata_o, 0);
    check("rst_req", bus.data_req, 0);
    check("rst_be", bus.data_be, 0);
    check("rst_addr", bus.data_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    add_beat(32'h100, 0, 4'b1000, 0, 0, 32'h80123456, 0, 0);
    run_op(0, 2'b00, 1, 32'h103, 0, 0, 1, 32'hFFFFFF80, 3);
    add_beat(32'h100, 0, 4'b1100, 0, 0, 32'hBEEF1234, 0, 0);
    run_op(0, 2'b01, 0, 32'h102, 0, 0, 1, 32'h0000BEEF, 3);
    add_beat(32'h100, 0, 4'b0011, 0, 0, 32'h1234F00D, 0, 0);
    run_op(0, 2'b01, 1, 32'h100, 0, 0, 1, 32'hFFFFF00D, 3);
    add_beat(32'h100, 0, 4'b0010, 0, 0, 32'h0000A500, 0, 0);
    run_op(0, 2'b00, 0, 32'h101, 0, 0, 1, 32'h000000A5, 3);
    add_beat(32'h104, 0, 4'b1111, 0, 0, 32'hCAFEF00D, 0, 0);
    run_op(0, 2'b10, 1, 32'h104, 0, 0, 1, 32'hCAFEF00D, 3);

    add_beat(32'h200, 1, 4'b1100, 32'hABCDABCD, 3, 0, 0, 0);
    run_op(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 0, 0, 0, 6);
    add_beat(32'h400, 1, 4'b0010, 32'h5A5A5A5A, 0, 0, 0, 0);
    run_op(1, 2'b00, 0, 32'h401, 32'h0000005A, 0, 0, 0, 3);
    add_beat(32'h500, 1, 4'b1111, 32'h01234567, 1, 0, 0, 0);
    run_op(1, 2'b10, 0, 32'h500, 32'h01234567, 0, 0, 0, 4);

    run_op(0, 2'b11, 0, 32'h010, 0, 1, 0, 0, 1);

`ifdef MISALIGNED_SPLIT_EN
    add_beat(32'h300, 0, 4'b1110, 0, 0, 32'h44332211, 0, 0);
    add_beat(32'h304, 0, 4'b0001, 0, 0, 32'h88776655, 0, 0);
    run_op(0, 2'b10, 0, 32'h301, 0, 0, 1, 32'h55443322, 5);
    add_beat(32'h200, 0, 4'b1000, 0, 0, 32'hAA000000, 0, 0);
    add_beat(32'h204, 0, 4'b0001, 0, 0, 32'h000000BB, 0, 0);
    run_op(0, 2'b01, 1, 32'h203, 0, 0, 1, 32'hFFFFBBAA, 5);
    add_beat(32'h200, 0, 4'b0110, 0, 0, 32'h00CDEF00, 0, 0);
    run_op(0, 2'b01, 0, 32'h201, 0, 0, 1, 32'h0000CDEF, 3);
`else
    run_op(0, 2'b10, 0, 32'h301, 0, 1, 0, 0, 1);
    run_op(0, 2'b01, 1, 32'h203, 0, 1, 0, 0, 1);
    run_op(0, 2'b01, 0, 32'h201, 0, 1, 0, 0, 1);
`endif

    add_beat(32'h600, 0, 4'b1111, 0, 0, 32'hDEADBEEF, 1, 0);
    run_op(0, 2'b10, 0, 32'h600, 0, 1, 1, 32'h0, 3);

    gnt_block = 1'b1;
    run_op(0, 2'b10, 0, 32'h700, 0, 1, 0, 0, 5);
    gnt_block = 1'b0;
    stray = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("stray_done", lsu_done_o, 0);
    check("stray_req", bus.data_req, 0);

    add_beat(32'h800, 0, 4'b1111, 0, 0, 32'h13579BDF, 0, 0);
    run_op(0, 2'b10, 0, 32'h800, 0, 0, 1, 32'h13579BDF, 3);

    add_beat(32'h700, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 0, 1);
    lsu_en_i       = 1'b1;
    lsu_we_i       = 1'b1;
    lsu_size_i     = 2'b01;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i     = 32'h702;
    lsu_wdata_i    = 32'h0000BEEF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_done", lsu_done_o, 0);
    check("mid_rst_err", lsu_err_o, 0);
    check("mid_rst_rdata", lsu_rdata_o, 0);
    check("mid_rst_req", bus.data_req, 0);
    check("mid_rst_we", bus.data_we, 0);
    check("mid_rst_be", bus.data_be, 0);
    check("mid_rst_addr", bus.data_addr, 0);
    check("mid_rst_wdata", bus.data_wdata, 0);
    lsu_en_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    add_beat(32'h900, 0, 4'b1000, 0, 0, 32'h7F000000, 0, 0);
    run_op(0, 2'b00, 1, 32'h903, 0, 0, 1, 32'h0000007F, 3);

    check("sb_empty", exp_q.size(), 0);
    check("beats_left", beat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
